// File: rtl/warp_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : warp_issue_arbiter
// Description : Round-robin warp issue arbiter. Picks one ready warp whose
//               target execution unit can take work, holds the issue on a
//               valid/ready handshake, pulses a scoreboard reservation on
//               accept and flags warps that name a non-existent unit.
// Revision    : 1.0 - initial release
// ============================================================================
module warp_issue_arbiter #(
  parameter  int NUM_WARPS = 32,
  parameter  int INSTR_W   = 63,
  parameter  int NUM_UNITS = 3,
  parameter  int ISSUE_GAP = 1,
  localparam int WID_W     = $clog2(NUM_WARPS),
  localparam int UID_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              issue_en,
  input  logic [NUM_WARPS-1:0]              warp_ready_mask,
  input  logic [NUM_WARPS-1:0][INSTR_W-1:0] instr_buf,
  input  logic [NUM_WARPS-1:0][31:0]        pred,
  input  logic [NUM_UNITS-1:0]              unit_ready,
  output logic                              iss_valid,
  input  logic                              iss_ready,
  output logic [WID_W-1:0]                  iss_warp,
  output logic [INSTR_W-1:0]                iss_instr,
  output logic [31:0]                       iss_pred,
  output logic [NUM_UNITS-1:0]              iss_unit,
  output logic                              sb_valid,
  output logic [WID_W-1:0]                  sb_warp,
  output logic [4:0]                        sb_rd,
  input  logic                              err_clr,
  output logic                              err_bad_unit
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Per-warp unit id and eligibility
  logic [UID_W-1:0]     uid [NUM_WARPS];
  logic [NUM_WARPS-1:0] uid_ok;
  logic [NUM_WARPS-1:0] elig;

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_elig
    logic unit_rdy;

    assign uid[gi]    = instr_buf[gi][UID_W-1:0];
    assign uid_ok[gi] = (32'(uid[gi]) < NUM_UNITS);

    // Ready bit of the unit this warp targets; an out-of-range id never matches
    always_comb begin
      unit_rdy = 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (uid[gi] == UID_W'(u)) unit_rdy = unit_ready[u];
      end
    end

    assign elig[gi] = warp_ready_mask[gi] & uid_ok[gi] & unit_rdy;
  end

  // Registered state
  state_t                 state_q, state_d;
  logic [WID_W-1:0]       last_grant_q, last_grant_d;
  logic                   iss_valid_q, iss_valid_d;
  logic [WID_W-1:0]       iss_warp_q, iss_warp_d;
  logic [INSTR_W-1:0]     iss_instr_q, iss_instr_d;
  logic [31:0]            iss_pred_q, iss_pred_d;
  logic [NUM_UNITS-1:0]   iss_unit_q, iss_unit_d;
  logic                   sb_valid_q, sb_valid_d;
  logic [WID_W-1:0]       sb_warp_q, sb_warp_d;
  logic [4:0]             sb_rd_q, sb_rd_d;
  logic                   err_q, err_d;

  // Round-robin search results
  logic                   found;
  logic [WID_W-1:0]       grant;
  logic [WID_W-1:0]       idx;
  logic [UID_W-1:0]       grant_uid;
  logic [NUM_UNITS-1:0]   grant_unit;
  logic                   bad_any;

  // First eligible warp at or after last_grant+1; the index wraps naturally
  // because NUM_WARPS is a power of two
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = last_grant_q + WID_W'(k) + WID_W'(1);
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // One-hot unit select of the winning warp
  always_comb begin
    grant_uid  = uid[grant];
    grant_unit = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      grant_unit[u] = (grant_uid == UID_W'(u));
    end
  end

  assign bad_any = |(warp_ready_mask & ~uid_ok);

  // Next-state and registered-output logic for the ARB/HOLD/GAP sequencer
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    iss_valid_d  = iss_valid_q;
    iss_warp_d   = iss_warp_q;
    iss_instr_d  = iss_instr_q;
    iss_pred_d   = iss_pred_q;
    iss_unit_d   = iss_unit_q;
    sb_valid_d   = 1'b0;
    sb_warp_d    = sb_warp_q;
    sb_rd_d      = sb_rd_q;
    // A new bad-unit sighting overrides a clear in the same cycle
    err_d        = bad_any ? 1'b1 : (err_clr ? 1'b0 : err_q);

    case (state_q)
      ARB: begin
        iss_valid_d = 1'b0;
        if (issue_en && found) begin
          iss_valid_d  = 1'b1;
          iss_warp_d   = grant;
          iss_instr_d  = instr_buf[grant];
          iss_pred_d   = pred[grant];
          iss_unit_d   = grant_unit;
          last_grant_d = grant;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        // Payload is frozen here regardless of ready-mask or unit changes
        if (iss_ready) begin
          iss_valid_d = 1'b0;
          sb_valid_d  = 1'b1;
          sb_warp_d   = iss_warp_q;
          sb_rd_d     = iss_instr_q[INSTR_W-1 -: 5];
          state_d     = (ISSUE_GAP != 0) ? GAP : ARB;
        end
      end
      GAP: begin
        iss_valid_d = 1'b0;
        state_d     = ARB;
      end
      default: begin
        iss_valid_d = 1'b0;
        state_d     = ARB;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      last_grant_q <= WID_W'(NUM_WARPS - 1);
      iss_valid_q  <= 1'b0;
      iss_warp_q   <= '0;
      iss_instr_q  <= '0;
      iss_pred_q   <= '0;
      iss_unit_q   <= '0;
      sb_valid_q   <= 1'b0;
      sb_warp_q    <= '0;
      sb_rd_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      iss_valid_q  <= iss_valid_d;
      iss_warp_q   <= iss_warp_d;
      iss_instr_q  <= iss_instr_d;
      iss_pred_q   <= iss_pred_d;
      iss_unit_q   <= iss_unit_d;
      sb_valid_q   <= sb_valid_d;
      sb_warp_q    <= sb_warp_d;
      sb_rd_q      <= sb_rd_d;
      err_q        <= err_d;
    end
  end

  assign iss_valid    = iss_valid_q;
  assign iss_warp     = iss_warp_q;
  assign iss_instr    = iss_instr_q;
  assign iss_pred     = iss_pred_q;
  assign iss_unit     = iss_unit_q;
  assign sb_valid     = sb_valid_q;
  assign sb_warp      = sb_warp_q;
  assign sb_rd        = sb_rd_q;
  assign err_bad_unit = err_q;

endmodule
`default_nettype wire

// File: tb/tb_warp_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_warp_issue_arbiter
// Description : Directed self-checking bench for warp_issue_arbiter. One
//               instance uses a one-cycle issue gap, a second shares the
//               inputs with back-to-back issue enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_warp_issue_arbiter;

  localparam int NW = 32;
  localparam int IW = 63;
  localparam int NU = 3;

  logic                     clk;
  logic                     rst_n;
  logic                     issue_en;
  logic [NW-1:0]            warp_ready_mask;
  logic [NW-1:0][IW-1:0]    instr_buf;
  logic [NW-1:0][31:0]      pred;
  logic [NU-1:0]            unit_ready;
  logic                     iss_ready;
  logic                     err_clr;

  logic                     iss_valid, sb_valid, err_bad_unit;
  logic [4:0]               iss_warp, sb_warp, sb_rd;
  logic [IW-1:0]            iss_instr;
  logic [31:0]              iss_pred;
  logic [NU-1:0]            iss_unit;

  logic                     d0_valid, d0_sb_valid, d0_err;
  logic [4:0]               d0_warp, d0_sb_warp, d0_sb_rd;
  logic [IW-1:0]            d0_instr;
  logic [31:0]              d0_pred;
  logic [NU-1:0]            d0_unit;

  warp_issue_arbiter #(.NUM_WARPS(NW), .INSTR_W(IW), .NUM_UNITS(NU), .ISSUE_GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .warp_ready_mask(warp_ready_mask),
    .instr_buf(instr_buf), .pred(pred), .unit_ready(unit_ready),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_warp(iss_warp),
    .iss_instr(iss_instr), .iss_pred(iss_pred), .iss_unit(iss_unit),
    .sb_valid(sb_valid), .sb_warp(sb_warp), .sb_rd(sb_rd),
    .err_clr(err_clr), .err_bad_unit(err_bad_unit)
  );

  warp_issue_arbiter #(.NUM_WARPS(NW), .INSTR_W(IW), .NUM_UNITS(NU), .ISSUE_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .warp_ready_mask(warp_ready_mask),
    .instr_buf(instr_buf), .pred(pred), .unit_ready(unit_ready),
    .iss_valid(d0_valid), .iss_ready(iss_ready), .iss_warp(d0_warp),
    .iss_instr(d0_instr), .iss_pred(d0_pred), .iss_unit(d0_unit),
    .sb_valid(d0_sb_valid), .sb_warp(d0_sb_warp), .sb_rd(d0_sb_rd),
    .err_clr(err_clr), .err_bad_unit(d0_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]    w;
    logic [IW-1:0] instr;
    logic [31:0]   pr;
    logic [NU-1:0] unit;
  } exp_t;

  exp_t      sbq[$];
  exp_t      last_e;
  logic [1:0] uid_tab [NW];
  int        vectors = 0;
  int        miscompares = 0;
  int        cyc = 0;
  int        rise = 0;

  function automatic logic [4:0] rd_of(input int w);
    return 5'(w) ^ 5'h15;
  endfunction

  function automatic logic [IW-1:0] mk_instr(input int w, input logic [1:0] u);
    return {rd_of(w), 56'(64'hC0DE_0000_0000 + 64'(w) * 64'h1111), u};
  endfunction

  function automatic logic [31:0] pred_of(input int w);
    return 32'hF000_0000 | (32'(w) * 32'h0101);
  endfunction

  task automatic rebuild();
    for (int i = 0; i < NW; i++) begin
      instr_buf[i] = mk_instr(i, uid_tab[i]);
      pred[i]      = pred_of(i);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int w);
    exp_t e;
    e.w     = 5'(w);
    e.instr = mk_instr(w, uid_tab[w]);
    e.pr    = pred_of(w);
    e.unit  = NU'(1 << uid_tab[w]);
    sbq.push_back(e);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (iss_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 64'(iss_valid), 64'd1);
  endtask

  // Pop the expected issue and compare the presented payload against it
  task automatic compare_issue(input string tag);
    check({tag, "_sbq_nonempty"}, 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() > 0) begin
      last_e = sbq.pop_front();
      check({tag, "_warp"},  64'(iss_warp),  64'(last_e.w));
      check({tag, "_instr"}, 64'(iss_instr), 64'(last_e.instr));
      check({tag, "_pred"},  64'(iss_pred),  64'(last_e.pr));
      check({tag, "_unit"},  64'(iss_unit),  64'(last_e.unit));
    end
  endtask

  // With iss_ready high, step over the accept edge and check the reservation
  task automatic accept_sb(input string tag);
    step();
    check({tag, "_sb_valid"}, 64'(sb_valid), 64'd1);
    check({tag, "_sb_warp"},  64'(sb_warp),  64'(last_e.w));
    check({tag, "_sb_rd"},    64'(sb_rd),    64'(rd_of(int'(last_e.w))));
    check({tag, "_drop"},     64'(iss_valid), 64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    issue_en        = 1'b0;
    warp_ready_mask = '1;
    unit_ready      = '1;
    iss_ready       = 1'b0;
    err_clr         = 1'b0;
    for (int i = 0; i < NW; i++) uid_tab[i] = 2'(i % 3);
    rebuild();

    // Reset state
    repeat (3) step();
    check("rst_valid", 64'(iss_valid), 64'd0);
    check("rst_warp",  64'(iss_warp),  64'd0);
    check("rst_instr", 64'(iss_instr), 64'd0);
    check("rst_pred",  64'(iss_pred),  64'd0);
    check("rst_unit",  64'(iss_unit),  64'd0);
    check("rst_sb",    64'(sb_valid),  64'd0);
    check("rst_sbrd",  64'(sb_rd),     64'd0);
    check("rst_err",   64'(err_bad_unit), 64'd0);
    check("rst_d0_valid", 64'(d0_valid), 64'd0);

    // All warps ready: strict rotation every 3 cycles, wrapping 31 -> 0
    rst_n     = 1'b1;
    issue_en  = 1'b1;
    iss_ready = 1'b1;
    for (int g = 0; g < 34; g++) begin
      push_exp(g % NW);
      wait_valid("rr");
      if (g > 0) check("rr_spacing", 64'(cyc - rise), 64'd3);
      rise = cyc;
      compare_issue("rr");
      accept_sb("rr");
    end

    // Warps 5 and 9: after granting 5 the next is 9, then back to 5
    warp_ready_mask = NW'(1) << 5;
    push_exp(5);  wait_valid("w5a"); compare_issue("w5a"); accept_sb("w5a");
    warp_ready_mask = (NW'(1) << 5) | (NW'(1) << 9);
    push_exp(9);  wait_valid("w9");  compare_issue("w9");  accept_sb("w9");
    push_exp(5);  wait_valid("w5b"); compare_issue("w5b"); accept_sb("w5b");

    // Hold warp 3 under back-pressure while its ready and all units drop
    warp_ready_mask = NW'(1) << 3;
    iss_ready       = 1'b0;
    push_exp(3);
    wait_valid("hold");
    compare_issue("hold");
    warp_ready_mask = '0;
    unit_ready      = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("hold_valid", 64'(iss_valid), 64'd1);
      check("hold_warp",  64'(iss_warp),  64'd3);
      check("hold_instr", 64'(iss_instr), 64'(mk_instr(3, uid_tab[3])));
      check("hold_unit",  64'(iss_unit),  64'(last_e.unit));
      check("hold_no_sb", 64'(sb_valid),  64'd0);
    end
    iss_ready = 1'b1;
    accept_sb("hold");
    step();
    check("hold_sb_pulse_end", 64'(sb_valid), 64'd0);
    unit_ready = '1;
    repeat (3) step();
    check("idle_no_grant", 64'(iss_valid), 64'd0);

    // Warp 2 blocked by its busy unit; warp 7 on unit 0 goes first
    uid_tab[2] = 2'd1;
    uid_tab[7] = 2'd0;
    rebuild();
    unit_ready      = 3'b101;
    warp_ready_mask = (NW'(1) << 2) | (NW'(1) << 7);
    push_exp(7); wait_valid("u7"); compare_issue("u7"); accept_sb("u7");
    check("u7_onehot", 64'(last_e.unit), 64'h1);
    warp_ready_mask = NW'(1) << 2;
    for (int c = 0; c < 6; c++) begin
      step();
      check("unit_busy_no_grant", 64'(iss_valid), 64'd0);
    end
    unit_ready = 3'b111;
    push_exp(2); wait_valid("u2"); compare_issue("u2"); accept_sb("u2");

    // Warp 4 names unit 3: sticky error, never granted, set beats clear
    check("err_pre", 64'(err_bad_unit), 64'd0);
    uid_tab[4] = 2'd3;
    rebuild();
    warp_ready_mask = NW'(1) << 4;
    step();
    check("err_set", 64'(err_bad_unit), 64'd1);
    warp_ready_mask = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("err_sticky", 64'(err_bad_unit), 64'd1);
      check("err_no_grant", 64'(iss_valid), 64'd0);
    end
    warp_ready_mask = NW'(1) << 4;
    err_clr         = 1'b1;
    step();
    check("err_set_wins", 64'(err_bad_unit), 64'd1);
    check("err_no_grant4", 64'(iss_valid), 64'd0);
    warp_ready_mask = '0;
    step();
    check("err_cleared", 64'(err_bad_unit), 64'd0);
    err_clr = 1'b0;
    step();
    check("err_stays_clear", 64'(err_bad_unit), 64'd0);
    uid_tab[4] = 2'd1;
    rebuild();

    // issue_en low blocks new grants
    issue_en        = 1'b0;
    warp_ready_mask = '1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("en_low_no_grant", 64'(iss_valid), 64'd0);
    end

    // Grant and hold, then reset mid-HOLD
    issue_en  = 1'b1;
    iss_ready = 1'b0;
    push_exp(3);
    wait_valid("pre_rst");
    compare_issue("pre_rst");
    step();
    check("pre_rst_held", 64'(iss_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(iss_valid), 64'd0);
    check("arst_warp",  64'(iss_warp),  64'd0);
    check("arst_instr", 64'(iss_instr), 64'd0);
    check("arst_pred",  64'(iss_pred),  64'd0);
    check("arst_unit",  64'(iss_unit),  64'd0);
    check("arst_sb",    64'(sb_valid),  64'd0);
    check("arst_d0_valid", 64'(d0_valid), 64'd0);
    iss_ready = 1'b1;
    repeat (2) step();
    check("arst_no_sb", 64'(sb_valid), 64'd0);
    check("arst_queue_empty", 64'(sbq.size()), 64'd0);

    // Back-to-back issue instance: rises every 2 cycles; both restart at warp 0
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      while (d0_valid !== 1'b1 && n < 12) begin
        step();
        n++;
      end
      check("b2b_valid", 64'(d0_valid), 64'd1);
      check("b2b_warp",  64'(d0_warp),  64'(k));
      check("b2b_instr", 64'(d0_instr), 64'(mk_instr(k, uid_tab[k])));
      if (k == 0) begin
        check("first_after_rst_valid", 64'(iss_valid), 64'd1);
        check("first_after_rst_warp",  64'(iss_warp),  64'd0);
      end else begin
        check("b2b_spacing", 64'(cyc - rise), 64'd2);
      end
      rise = cyc;
      step();
      check("b2b_drop",    64'(d0_valid),    64'd0);
      check("b2b_sb",      64'(d0_sb_valid), 64'd1);
      check("b2b_sb_warp", 64'(d0_sb_warp),  64'(k));
      check("b2b_sb_rd",   64'(d0_sb_rd),    64'(rd_of(k)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
